beamformer_sequencer: RTL
=========================

// Module: beamformer_sequencer
// PURPOSE
// - Control stage directly upstream of the BRAM delay-beamformer datapath; drives all of its control inputs.
// - On a start pulse: primes the beamformer (slice_idle_delay), streams three input slices from the signal RAM, drains, then reads the summed output RAM back out.
// - Owns every address and index counter, so the datapath block stays free of sequencing logic.
// PARAMETERS
// - ADDR_W      11   width of readin_address / sumout_address
// - IDX_W       16   width of sample_index
// - SLICE_LEN   682  samples per slice; 3*SLICE_LEN <= 2**ADDR_W is required
// - PRIME_CYC   4    cycles spent in slice_idle_delay before slice1
// - RAM_LAT     1    read latency of both signal RAMs, in clk cycles
// - DRAIN_CYC   16   consecutive usedataflag-low cycles needed to end DRAIN
// - OUT_LEN     2048 words read back from the output RAM
// PORTS
// - clk              in   1       system clock, rising edge
// - rst              in   1       asynchronous reset, active-high
// - start            in   1       1-cycle request; sampled only in IDLE
// - abort            in   1       synchronous abort to IDLE; has priority over all other transitions
// - usedataflag      in   1       beamformer data_good, fed back
// - startbeamformer  out  1       enable for the beamformer and input buffer
// - readinen         out  1       input RAM read enable
// - readin_address   out  ADDR_W  input RAM address
// - slice_state      out  2       0=idle_delay, 1=slice1, 2=slice2, 3=slice3
// - sample_index     out  IDX_W   index of the sample currently presented to the beamformer
// - sumouten         out  1       output RAM read enable
// - sumout_address   out  ADDR_W  output RAM address
// - out_valid        out  1       output RAM q is valid this cycle
// - busy             out  1       high in every state except IDLE
// - done             out  1       1-cycle pulse when READOUT completes
// BEHAVIOUR
// - Reset values: all outputs 0, except sample_index = all-ones (-1). State = IDLE.
// - FSM: IDLE -> PRIME -> SLICE1 -> SLICE2 -> SLICE3 -> DRAIN -> READOUT -> IDLE.
// - IDLE: outputs at reset values. start=1 -> PRIME on the next edge. start in any other state is ignored.
// - PRIME: startbeamformer=1, slice_state=0, readinen=0. Lasts exactly PRIME_CYC cycles.
// - SLICEk (k=1..3): startbeamformer=1, readinen=1, slice_state=k.
//   - readin_address increments by 1 every cycle, continuously across slices: slice k covers (k-1)*SLICE_LEN .. k*SLICE_LEN-1.
//   - Each slice lasts exactly SLICE_LEN cycles.
// - sample_index = readin_address delayed by RAM_LAT cycles, zero-extended to IDX_W.
//   - Holds -1 until the first delayed address arrives; holds its last value after SLICE3.
// - DRAIN: readinen=0, startbeamformer=1.
//   - A counter counts consecutive usedataflag=0 cycles; a 1 clears it.
//   - Exit to READOUT when the count reaches DRAIN_CYC.
// - READOUT: startbeamformer=0, sumouten=1, sumout_address runs 0..OUT_LEN-1, one address per cycle.
//   - out_valid = sumouten delayed by RAM_LAT, so exactly OUT_LEN valid cycles.
//   - done pulses on the cycle of the last out_valid; the FSM then returns to IDLE.
// - Address counters wrap modulo 2**ADDR_W; with legal parameters no wrap occurs.
// - abort: next edge -> IDLE, outputs at reset values, counters cleared, done not pulsed.
// - Simultaneous start+abort in IDLE: stays in IDLE.
// - rst asserted mid-operation: immediate return to reset values; no partial done.
// STRUCTURE
// - Shared package bf_pkg:
//   - state enum {IDLE, PRIME, SLICE1, SLICE2, SLICE3, DRAIN, READOUT}
//   - slice_state encodings SLICE_IDLE_DELAY=0, SLICE1=1, SLICE2=2, SLICE3=3, shared with the datapath
// - One sub-module bf_delay_line (parameterised width/depth shift register): used for the sample_index delay and the out_valid delay.
// - FSM, phase counter, address counters and drain counter stay in the top level.
// TESTING
// - Reset, then idle 10 cycles -> every output at its reset value; sample_index=16'hFFFF; busy=0.
// - start pulse, defaults:
//   - slice_state=0 for 4 cycles, then 1 for 682 cycles, 2 for 682, 3 for 682.
//   - readin_address runs 0..2045 with no gaps.
//   - sample_index lags readin_address by exactly 1 cycle.
// - DRAIN with usedataflag high 5 cycles, low 3, high 1, low 16 -> READOUT entered exactly after the 16th consecutive low.
// - READOUT -> sumout_address 0..2047; out_valid high 2048 cycles starting 1 cycle after sumouten; done pulses once, on the last valid cycle.
// - abort asserted in SLICE2 at readin_address=900 -> IDLE next cycle, outputs at reset values, no done; a new start replays the full run from address 0.
// - rst pulsed during READOUT -> outputs drop to reset values asynchronously; start pulses while busy are ignored (run length unchanged).

Source files
------------

// File: rtl/bf_pkg.sv
// Shared types and encodings for the beamformer sequencer and its datapath.
// The slice_state encodings are also used by the downstream datapath.
package bf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_SLICE1,
    ST_SLICE2,
    ST_SLICE3,
    ST_DRAIN,
    ST_READOUT
  } bf_state_e;

  localparam logic [1:0] SLICE_IDLE_DELAY = 2'd0;
  localparam logic [1:0] SLICE1           = 2'd1;
  localparam logic [1:0] SLICE2           = 2'd2;
  localparam logic [1:0] SLICE3           = 2'd3;

endpackage

// File: rtl/bf_delay_line.sv
// Fixed-depth shift register used to align control bits with the RAM read latency.
// DEPTH must be at least 1; clr_i flushes every stage synchronously.
module bf_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/beamformer_sequencer.sv
// Sequencer driving the BRAM delay-beamformer: prime, three input slices, drain, readout.
// Handshake: start is a 1-cycle request honoured only in IDLE; abort wins over every transition.
module beamformer_sequencer
  import bf_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int IDX_W     = 16,
  parameter int SLICE_LEN = 682,
  parameter int PRIME_CYC = 4,
  parameter int RAM_LAT   = 1,
  parameter int DRAIN_CYC = 16,
  parameter int OUT_LEN   = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              usedataflag,
  output logic              startbeamformer,
  output logic              readinen,
  output logic [ADDR_W-1:0] readin_address,
  output logic [1:0]        slice_state,
  output logic [IDX_W-1:0]  sample_index,
  output logic              sumouten,
  output logic [ADDR_W-1:0] sumout_address,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output bf_state_e         state_dbg
);

  localparam int PH_W = $clog2(SLICE_LEN + PRIME_CYC + 1);
  localparam int DR_W = $clog2(DRAIN_CYC + 1);
  localparam int OC_W = ADDR_W + 1;

  localparam logic [PH_W-1:0] PRIME_LAST = PH_W'(PRIME_CYC - 1);
  localparam logic [PH_W-1:0] SLICE_LAST = PH_W'(SLICE_LEN - 1);
  localparam logic [DR_W-1:0] DRAIN_LAST = DR_W'(DRAIN_CYC - 1);
  localparam logic [OC_W-1:0] OUT_END    = OC_W'(OUT_LEN);
  localparam logic [OC_W-1:0] OUT_LAST   = OC_W'(OUT_LEN - 1);

  bf_state_e         state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DR_W-1:0]   drain_q, drain_d;
  logic [OC_W-1:0]   out_cnt_q, out_cnt_d;
  logic [IDX_W-1:0]  idx_hold_q, idx_hold_d;
  logic [ADDR_W:0]   rd_dl;
  logic [1:0]        ov_dl;
  logic              clr_w;
  logic              last_w;

  always_comb begin
    state_d         = state_q;
    phase_d         = phase_q;
    addr_d          = addr_q;
    drain_d         = drain_q;
    out_cnt_d       = out_cnt_q;
    startbeamformer = 1'b0;
    readinen        = 1'b0;
    slice_state     = SLICE_IDLE_DELAY;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_PRIME;
      ST_PRIME: begin
        startbeamformer = 1'b1;
        if (phase_q == PRIME_LAST) begin
          phase_d = '0;
          state_d = ST_SLICE1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_SLICE1, ST_SLICE2, ST_SLICE3: begin
        startbeamformer = 1'b1;
        readinen        = 1'b1;
        addr_d          = addr_q + 1'b1;
        slice_state     = (state_q == ST_SLICE1) ? SLICE1 :
                          (state_q == ST_SLICE2) ? SLICE2 : SLICE3;
        if (phase_q == SLICE_LAST) begin
          phase_d = '0;
          state_d = (state_q == ST_SLICE1) ? ST_SLICE2 :
                    (state_q == ST_SLICE2) ? ST_SLICE3 : ST_DRAIN;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // Beamformer keeps running on slice 3 data until its output goes quiet.
        startbeamformer = 1'b1;
        slice_state     = SLICE3;
        if (usedataflag) begin
          drain_d = '0;
        end else if (drain_q == DRAIN_LAST) begin
          drain_d = '0;
          state_d = ST_READOUT;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      ST_READOUT: begin
        if (sumouten) out_cnt_d = out_cnt_q + 1'b1;
        if (done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
    if (state_d == ST_IDLE) begin
      phase_d   = '0;
      addr_d    = '0;
      drain_d   = '0;
      out_cnt_d = '0;
    end
  end

  assign clr_w          = (state_d == ST_IDLE);
  assign busy           = (state_q != ST_IDLE);
  assign readin_address = addr_q;
  assign sumouten       = (state_q == ST_READOUT) && (out_cnt_q < OUT_END);
  assign sumout_address = out_cnt_q[ADDR_W-1:0];
  assign last_w         = sumouten && (out_cnt_q == OUT_LAST);
  assign state_dbg      = state_q;

  // Address travels with its read enable so sample_index only moves on real reads.
  bf_delay_line #(.W(ADDR_W + 1), .DEPTH(RAM_LAT)) u_idx_dly (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (clr_w),
    .d_i   ({readinen, readin_address}),
    .q_o   (rd_dl)
  );

  bf_delay_line #(.W(2), .DEPTH(RAM_LAT)) u_ov_dly (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (clr_w),
    .d_i   ({sumouten, last_w}),
    .q_o   (ov_dl)
  );

  assign out_valid    = ov_dl[1];
  assign done         = ov_dl[0];
  assign sample_index = rd_dl[ADDR_W] ? IDX_W'(rd_dl[ADDR_W-1:0]) : idx_hold_q;
  assign idx_hold_d   = clr_w ? '1 : sample_index;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      addr_q     <= '0;
      drain_q    <= '0;
      out_cnt_q  <= '0;
      idx_hold_q <= '1;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      addr_q     <= addr_d;
      drain_q    <= drain_d;
      out_cnt_q  <= out_cnt_d;
      idx_hold_q <= idx_hold_d;
    end
  end

endmodule
